alu_sched: RTL and testbench

Round-robin scheduler that shares one `tinyalu` instance between `N_REQ` requesters. It accepts operations over per-requester valid/ready handshakes and drives the ALU's `start`/`op`/`A`/`B` with the start-held-until-done protocol. Each result is returned on a single tagged response channel with backpressure. It sits between the requesting datapath blocks and the `tinyalu` instance, and guards against a hung ALU with a completion timeout.

---
 rtl/alu_sched_pkg.sv | 23 ++
 rtl/alu_sched_rr_arbiter.sv | 40 ++++
 rtl/alu_sched.sv | 124 ++++++++++++
 tb/tb_alu_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared opcodes, FSM states and operation record for the tinyalu scheduler.
package alu_sched_pkg;

  localparam logic [2:0]  OP_NOP     = 3'd0;
  localparam logic [2:0]  OP_ADD     = 3'd1;
  localparam logic [2:0]  OP_AND     = 3'd2;
  localparam logic [2:0]  OP_XOR     = 3'd3;
  localparam logic [2:0]  OP_MUL     = 3'd4;
  localparam logic [15:0] ERR_RESULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin one-hot arbiter; pointer holds the last granted index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic          hit;
  int            idx;

  // Walk farthest-to-nearest so the closest requester after ptr wins last.
  always_comb begin
    hit  = 1'b0;
    gidx = ptr;
    idx  = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[IW'(idx)]) begin
        hit  = 1'b1;
        gidx = IW'(idx);
      end
    end
  end

  assign grant = hit ? ({{(N-1){1'b0}}, 1'b1} << gidx) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ptr <= IW'(N - 1);
    else if (advance) ptr <= gidx;
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one tinyalu between N_REQ requesters: round-robin accept, one op in
// flight, start held until done or timeout, tagged response with backpressure.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0][7:0]      req_a,
  input  logic [N_REQ-1:0][7:0]      req_b,
  input  logic [N_REQ-1:0][2:0]      req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [15:0]                rsp_result,
  output logic                       rsp_err,
  output logic                       alu_start,
  output logic [2:0]                 alu_op,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  input  logic                       alu_done,
  input  logic [15:0]                alu_result
);

  localparam int IW = $clog2(N_REQ);

  state_t           state;
  logic [7:0]       to_cnt;
  logic [7:0]       to_nxt;
  logic [N_REQ-1:0] grant;
  logic             accept;
  logic [IW-1:0]    sel;
  alu_req_t         pick;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) sel = IW'(i);
  end

  assign pick   = '{op: req_op[sel], a: req_a[sel], b: req_b[sel]};
  assign to_nxt = (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      to_cnt     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= sel;
            alu_op <= pick.op;
            alu_a  <= pick.a;
            alu_b  <= pick.b;
            to_cnt <= '0;
            if (pick.op == OP_NOP) begin
              rsp_result <= ERR_RESULT;
              rsp_err    <= 1'b0;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else if (pick.op <= OP_MUL) begin
              alu_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              rsp_result <= ERR_RESULT;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          to_cnt <= to_nxt;
          // done takes priority over a timeout landing on the same edge
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            alu_start  <= 1'b0;
            state      <= RESP;
          end else if (to_nxt >= 8'(TIMEOUT)) begin
            rsp_result <= ERR_RESULT;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            alu_start  <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched with a behavioural tinyalu (hang and latency knobs).
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N-1:0][7:0] req_a;
  logic [N-1:0][7:0] req_b;
  logic [N-1:0][2:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_result;
  logic              rsp_err;
  logic              alu_start;
  logic [2:0]        alu_op;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic              alu_done   = 1'b0;
  logic [15:0]       alu_result = 16'h0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   hang = 1'b0;
  int   lat_ovr = -1;
  int   busy = 0;
  int   start_cnt = 0;

  alu_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h0, a & b};
      3'd3:    return {8'h0, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0;
    endcase
  endfunction

  // tinyalu stand-in: done is a one-cycle pulse after a per-op latency
  always @(posedge clk) begin
    if (!reset_n) begin
      alu_done <= 1'b0;
      busy     <= 0;
    end else if (alu_done) begin
      alu_done <= 1'b0;
    end else if (alu_start && !hang) begin
      if (busy >= ((lat_ovr >= 0) ? lat_ovr : ((alu_op == 3'd4) ? 2 : 0))) begin
        alu_done   <= 1'b1;
        alu_result <= alu_fn(alu_op, alu_a, alu_b);
        busy       <= 0;
      end else begin
        busy <= busy + 1;
      end
    end else begin
      busy <= 0;
    end
  end

  always @(negedge clk) if (alu_start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[i] = op;
    req_a[i]  = a;
    req_b[i]  = b;
  endtask

  task automatic wait_rsp();
    for (int t = 0; t < 60 && rsp_valid !== 1'b1; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b vld=%b id=%0d res=%h err=%b start=%b op=%0d a=%h b=%h, want all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    set_req(1, 3'd1, 8'd200, 8'd55);
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL single_grant: got %b want 0010", req_ready);
    end
    sb.push_back('{id: 2'd1, res: 16'd255, err: 1'b0});
    @(negedge clk);
    req_valid = '0;
    n_vec++;
    if (alu_start !== 1'b1 || alu_a !== 8'd200 || alu_b !== 8'd55 || alu_op !== 3'd1) begin
      n_err++; $display("FAIL single_issue: start=%b a=%0d b=%0d op=%0d want 1/200/55/1", alu_start, alu_a, alu_b, alu_op);
    end
    wait_rsp();
    e = sb.pop_front();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err) begin
      n_err++; $display("FAIL single_rsp: vld=%b id=%0d res=%0d err=%b want 1/%0d/%0d/%b", rsp_valid, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
    end
    n_vec++;
    if (alu_start !== 1'b0) begin
      n_err++; $display("FAIL single_start_low: got %b want 0", alu_start);
    end
    @(negedge clk);
    n_vec++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_after: start=%b vld=%b want 0/0", alu_start, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] one;
    int t;
    one = 4'b0001;
    reset_n = 1'b0; #1; @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 3'd4, 8'(i + 1), 8'd10);
    rsp_ready = 1'b1; req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      t = 0;
      while (req_ready === '0 && t < 60) begin @(negedge clk); t++; end
      n_vec++;
      if (req_ready !== (one << (g % 4))) begin
        n_err++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, one << (g % 4));
      end
      sb.push_back('{id: 2'(g % 4), res: 16'((g % 4 + 1) * 10), err: 1'b0});
      @(negedge clk);
      if (g == 4) req_valid = '0;
      wait_rsp();
      e = sb.pop_front();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err) begin
        n_err++; $display("FAIL rr_rsp%0d: vld=%b id=%0d res=%0d err=%b want 1/%0d/%0d/%b", g, rsp_valid, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_nop_illegal();
    int s0;
    s0 = start_cnt;
    set_req(2, 3'd0, 8'd9, 8'd9);
    req_valid = 4'b0100;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL nop_grant: got %b want 0100", req_ready);
    end
    sb.push_back('{id: 2'd2, res: 16'h0, err: 1'b0});
    @(negedge clk);
    req_valid = '0;
    e = sb.pop_front();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err) begin
      n_err++; $display("FAIL nop_rsp: vld=%b id=%0d res=%h err=%b want 1/%0d/%h/%b", rsp_valid, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
    end
    @(negedge clk);
    set_req(2, 3'd6, 8'd1, 8'd2);
    req_valid = 4'b0100;
    #1;
    sb.push_back('{id: 2'd2, res: 16'h0, err: 1'b1});
    @(negedge clk);
    req_valid = '0;
    e = sb.pop_front();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err) begin
      n_err++; $display("FAIL illegal_rsp: vld=%b id=%0d res=%h err=%b want 1/%0d/%h/%b", rsp_valid, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
    end
    @(negedge clk);
    n_vec++;
    if (start_cnt !== s0) begin
      n_err++; $display("FAIL nop_no_start: start high %0d cycles want 0", start_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    int hi;
    // hung ALU, then done on the timeout edge, then a normal op
    for (int v = 0; v < 3; v++) begin
      hang    = (v == 0);
      lat_ovr = (v == 1) ? 14 : -1;
      case (v)
        0: begin set_req(0, 3'd1, 8'd3, 8'd4);     req_valid = 4'b0001; sb.push_back('{id: 2'd0, res: 16'h0000, err: 1'b1}); end
        1: begin set_req(1, 3'd2, 8'hF0, 8'h3C);   req_valid = 4'b0010; sb.push_back('{id: 2'd1, res: 16'h0030, err: 1'b0}); end
        default: begin set_req(2, 3'd3, 8'hF0, 8'h3C); req_valid = 4'b0100; sb.push_back('{id: 2'd2, res: 16'h00CC, err: 1'b0}); end
      endcase
      #1;
      n_vec++;
      if (req_ready !== req_valid) begin
        n_err++; $display("FAIL to_grant%0d: got %b want %b", v, req_ready, req_valid);
      end
      @(negedge clk);
      req_valid = '0;
      hi = 0;
      for (int t = 0; t < 60 && rsp_valid !== 1'b1; t++) begin
        if (alu_start === 1'b1) hi++;
        @(negedge clk);
      end
      if (v < 2) begin
        n_vec++;
        if (hi != TO) begin
          n_err++; $display("FAIL to_start_len%0d: start high %0d cycles want %0d", v, hi, TO);
        end
      end
      e = sb.pop_front();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err) begin
        n_err++; $display("FAIL to_rsp%0d: vld=%b id=%0d res=%h err=%b want 1/%0d/%h/%b", v, rsp_valid, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
      end
      @(negedge clk);
    end
    hang = 1'b0; lat_ovr = -1;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(0, 3'd1, 8'd5, 8'd6);
    req_valid = 4'b0001;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL bp_grant0: got %b want 0001", req_ready);
    end
    sb.push_back('{id: 2'd0, res: 16'd11, err: 1'b0});
    @(negedge clk);
    set_req(3, 3'd2, 8'hAA, 8'h0F);
    req_valid = 4'b1000;
    #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++; $display("FAIL bp_busy_ready: got %b want 0000", req_ready);
    end
    wait_rsp();
    e = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err || req_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_hold%0d: vld=%b id=%0d res=%0d err=%b rdy=%b want 1/%0d/%0d/%b/0000",
                          c, rsp_valid, rsp_id, rsp_result, rsp_err, req_ready, e.id, e.res, e.err);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    sb.push_back('{id: 2'd3, res: 16'h000A, err: 1'b0});
    @(negedge clk);
    n_vec++;
    if (req_ready !== 4'b1000) begin
      n_err++; $display("FAIL bp_grant3: got %b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp();
    e = sb.pop_front();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err) begin
      n_err++; $display("FAIL bp_rsp3: vld=%b id=%0d res=%h err=%b want 1/%0d/%h/%b", rsp_valid, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_req(2, 3'd4, 8'd7, 8'd9);
    req_valid = 4'b0100;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL rm_grant: got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    n_vec++;
    if (alu_start !== 1'b1) begin
      n_err++; $display("FAIL rm_issue: start=%b want 1", alu_start);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rm_async: start=%b vld=%b want 0/0", alu_start, rsp_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rm_no_rsp: vld=%b want 0", rsp_valid);
    end
    for (int i = 0; i < N; i++) set_req(i, 3'd1, 8'(i), 8'(i + 10));
    req_valid = '1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rm_first_grant: got %b want 0001", req_ready);
    end
    sb.push_back('{id: 2'd0, res: 16'd10, err: 1'b0});
    @(negedge clk);
    req_valid = '0;
    wait_rsp();
    e = sb.pop_front();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err) begin
      n_err++; $display("FAIL rm_rsp: vld=%b id=%0d res=%0d err=%b want 1/%0d/%0d/%b", rsp_valid, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_nop_illegal();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
